// File: rtl/out_drain.sv
// Purpose: drains a programmed range of outmem rows and streams each row's lanes over valid/ready.
// Latency: start -> first o_valid in 3 cycles; col+2 cycles per row with o_ready held high.
// Backpressure: o_valid holds lane data, row and column stable until o_ready accepts it.
// Optional feature: define OUT_DRAIN_SAT_EN to shift and saturate each lane to signed 16-bit at capture.
module out_drain #(
  parameter int bw       = 8,
  parameter int bw_psum  = 20,
  parameter int col      = 8,
  parameter int shift    = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [3:0]                             base_addr,
  input  logic [4:0]                             num_rows,
  output logic                                   outmem_rd,
  output logic [3:0]                             outmem_add,
  input  logic [(bw_psum+bw+4)*col-1:0]          outmem_q,
  output logic [bw_psum+bw+4-1:0]                o_data,
  output logic                                   o_valid,
  input  logic                                   o_ready,
  output logic [3:0]                             o_row,
  output logic [((col > 1) ? $clog2(col) : 1)-1:0] o_col,
  output logic                                   o_last,
  output logic                                   busy,
  output logic                                   done
);

  localparam int bw_out = bw_psum + bw + 4;
  localparam int CW     = (col > 1) ? $clog2(col) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(col - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              base_q;
  logic [4:0]              nrows_q;
  logic [4:0]              row_cnt;
  logic [4:0]              row_cnt_inc;
  logic [CW-1:0]           col_idx;
  logic [3:0]              add_q;
  logic [3:0]              rd_addr;
  logic [4:0]              nrows_clamped;
  logic [bw_out*col-1:0]   row_buf;
  logic                    last_col;
  logic                    accept;

`ifdef OUT_DRAIN_SAT_EN
  localparam logic signed [bw_out-1:0] SAT_MAX = bw_out'(32767);
  localparam logic signed [bw_out-1:0] SAT_MIN = -bw_out'(32768);

  // Arithmetic shift then clamp to the signed 16-bit range, sign-extended to lane width.
  function automatic logic [bw_out-1:0] lane_xform(input logic [bw_out-1:0] v);
    logic signed [bw_out-1:0] s;
    s = $signed(v) >>> shift;
    if (s > SAT_MAX) begin
      return SAT_MAX;
    end
    if (s < SAT_MIN) begin
      return SAT_MIN;
    end
    return s;
  endfunction
`else
  // Raw lane pass-through; shift only matters when saturation is built in.
  function automatic logic [bw_out-1:0] lane_xform(input logic [bw_out-1:0] v);
    return v;
  endfunction

  logic unused_shift;
  assign unused_shift = (shift != 0);
`endif

  assign rd_addr       = 4'(base_q + row_cnt[3:0]);
  assign row_cnt_inc   = 5'(row_cnt + 5'd1);
  assign nrows_clamped = (num_rows > 5'd16) ? 5'd16 : num_rows;
  assign last_col      = (col_idx == LAST_COL);
  assign accept        = (state == S_SEND) && o_ready;

  // Address bus shows the live read address in READ and otherwise holds the last one driven.
  assign outmem_add = (state == S_READ) ? rd_addr : add_q;
  assign o_data     = row_buf[int'(col_idx)*bw_out +: bw_out];
  assign o_row      = add_q;
  assign o_col      = col_idx;
  assign o_last     = o_valid && last_col && (row_cnt_inc == nrows_q);

  // State register; reset aborts any drain in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    outmem_rd = 1'b0;
    o_valid   = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_rows == 5'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        outmem_rd = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        o_valid = 1'b1;
        if (o_ready && last_col) begin
          state_nxt = (row_cnt_inc == nrows_q) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: latch the request, track row/lane counters, capture the returned row.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      nrows_q <= '0;
      row_cnt <= '0;
      col_idx <= '0;
      add_q   <= '0;
      row_buf <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            nrows_q <= nrows_clamped;
            row_cnt <= '0;
            col_idx <= '0;
          end
        end
        S_READ: begin
          add_q <= rd_addr;
        end
        S_WAIT: begin
          // outmem_q carries the row requested last cycle; it may change afterwards.
          for (int k = 0; k < col; k++) begin
            row_buf[k*bw_out +: bw_out] <= lane_xform(outmem_q[k*bw_out +: bw_out]);
          end
          col_idx <= '0;
        end
        S_SEND: begin
          if (accept) begin
            if (last_col) begin
              col_idx <= '0;
              row_cnt <= row_cnt_inc;
            end else begin
              col_idx <= col_idx + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_drain.sv
// Directed bench for out_drain with an outmem model and a lane/address scoreboard.
// Outmem model returns a row the cycle after the read strobe, then scrambles its output.
// Expected lanes and read addresses are queued at start and consumed as the DUT produces them.
module tb_out_drain;

  localparam int BW_OUT = 32;
  localparam int COL    = 8;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  row;
    logic [2:0]  col;
    logic        last;
  } lane_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   base_addr;
  logic [4:0]   num_rows;
  logic         outmem_rd;
  logic [3:0]   outmem_add;
  logic [255:0] outmem_q;
  logic [31:0]  o_data;
  logic         o_valid;
  logic         o_ready;
  logic [3:0]   o_row;
  logic [2:0]   o_col;
  logic         o_last;
  logic         busy;
  logic         done;

  logic [255:0] mem [16];
  lane_t        sbq [$];
  logic [3:0]   addq [$];
  int           tests = 0;
  int           fails = 0;
  int           cyc   = 0;

  always #5 clk = ~clk;

  out_drain dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .outmem_rd  (outmem_rd),
    .outmem_add (outmem_add),
    .outmem_q   (outmem_q),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_row      (o_row),
    .o_col      (o_col),
    .o_last     (o_last),
    .busy       (busy),
    .done       (done)
  );

  // Outmem: row appears one cycle after the strobe, then the bus is scrambled.
  always @(posedge clk) begin
    if (outmem_rd) outmem_q <= mem[outmem_add];
    else           outmem_q <= ~outmem_q;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_lane(input logic [31:0] v);
`ifdef OUT_DRAIN_SAT_EN
    logic signed [31:0] s;
    s = $signed(v) >>> 8;
    if (s > 32'sd32767)  return 32'h0000_7FFF;
    if (s < -32'sd32768) return 32'hFFFF_8000;
    return s;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input logic [3:0] base, input logic [4:0] rows);
    int    n;
    lane_t e;
    logic [3:0] a;
    n = (rows > 5'd16) ? 16 : int'(rows);
    for (int r = 0; r < n; r++) begin
      a = 4'(base + r);
      addq.push_back(a);
      for (int k = 0; k < COL; k++) begin
        e.d    = exp_lane(mem[a][k*BW_OUT +: BW_OUT]);
        e.row  = a;
        e.col  = 3'(k);
        e.last = (r == n - 1) && (k == COL - 1);
        sbq.push_back(e);
      end
    end
  endtask

  // Check this cycle's read strobe and offered lane against the scoreboard.
  task automatic observe();
    lane_t e;
    if (outmem_rd) begin
      if (addq.size() == 0) chk("rd_extra", outmem_rd, 0);
      else                  chk("rd_add", outmem_add, addq.pop_front());
    end
    if (o_valid) begin
      if (sbq.size() == 0) begin
        chk("valid_extra", o_valid, 0);
      end else begin
        e = sbq[0];
        chk("o_data", o_data, e.d);
        chk("o_row", o_row, e.row);
        chk("o_col", o_col, e.col);
        chk("o_last", o_last, e.last);
        if (o_ready) void'(sbq.pop_front());
      end
    end else begin
      chk("last_idle", o_last, 0);
    end
  endtask

  task automatic run_drain(input logic [3:0] base, input logic [4:0] rows,
                           input bit bp, input bit mid_start, input int exp_done);
    int done_cyc;
    int first_v;
    done_cyc = -1;
    first_v  = -1;
    push_exp(base, rows);
    base_addr = base;
    num_rows  = rows;
    start     = 1'b1;
    o_ready   = 1'b1;
    cyc       = 0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && done_cyc < 0; i++) begin
      o_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      start   = mid_start && (cyc == 5);
      if (start) begin
        base_addr = 4'(base + 4'd7);
        num_rows  = 5'd0;
      end
      chk("busy", busy, 1);
      observe();
      if (o_valid && first_v < 0) first_v = cyc;
      if (done) done_cyc = cyc;
      else      tick();
    end
    start = 1'b0;
    if (exp_done > 0) chk("done_cyc", done_cyc, exp_done);
    else              chk("done_seen", done_cyc > 0, 1);
    chk("first_valid", first_v, (rows == 0) ? -1 : 3);
    chk("sb_empty", sbq.size(), 0);
    chk("addq_empty", addq.size(), 0);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    bit hit;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < COL; k++) begin
        mem[r][k*BW_OUT +: BW_OUT] = (r == 3) ? 32'(100 + k) : 32'($urandom);
      end
    end
`ifdef OUT_DRAIN_SAT_EN
    mem[9] = '0;
    mem[9][0*32 +: 32] = 32'h1234_0000;
    mem[9][1*32 +: 32] = 32'hFF00_0000;
    mem[9][2*32 +: 32] = 32'h0000_1280;
`endif
    outmem_q  = '0;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    o_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    chk("rst_rd", outmem_rd, 0);
    chk("rst_add", outmem_add, 0);
    chk("rst_data", o_data, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_row", o_row, 0);
    chk("rst_col", o_col, 0);
    chk("rst_last", o_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Basic single row, done in cycle 11.
    run_drain(4'd3, 5'd1, 1'b0, 1'b0, 11);
    // Address wrap across 15 -> 0.
    run_drain(4'd14, 5'd4, 1'b0, 1'b0, 41);
    chk("add_hold", outmem_add, 4'd1);
    // Zero rows: done in cycle 1, no reads or lanes.
    run_drain(4'd6, 5'd0, 1'b0, 1'b0, 1);
    // Backpressure with an ignored mid-drain start.
    run_drain(4'd2, 5'd3, 1'b1, 1'b1, 0);
    // Oversized row count clamps to 16.
    run_drain(4'd0, 5'd20, 1'b0, 1'b0, 161);
`ifdef OUT_DRAIN_SAT_EN
    run_drain(4'd9, 5'd1, 1'b0, 1'b0, 11);
`endif

    // Reset in the middle of row index 2, lane 4.
    push_exp(4'd5, 5'd4);
    base_addr = 4'd5;
    num_rows  = 5'd4;
    start     = 1'b1;
    o_ready   = 1'b1;
    cyc       = 0;
    tick();
    start = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      observe();
      if (o_valid && o_row == 4'd7 && o_col == 3'd4) hit = 1'b1;
      else tick();
    end
    chk("abort_point", hit, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", o_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd", outmem_rd, 0);
    tick();
    chk("abort_rd2", outmem_rd, 0);
    sbq.delete();
    addq.delete();
    run_drain(4'd5, 5'd4, 1'b0, 1'b0, 41);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
